instruction_encoder: RTL and testbench
======================================

// Module: instruction_encoder
// PURPOSE
//  Transmit-side partner of the CPU instruction decoder. Accepts one symbolic instruction per
//  handshake (opcode plus operand fields), packs it into the 16-bit word format the decoder
//  expects, and writes the words sequentially into program memory from address 0.
//  Sits between the test/boot loader and program memory; owns the program write pointer.
// PARAMETERS
//  INSTRUCTION_WIDTH  16  encoded word width
//  RF_ADDR_WIDTH       2  register-file address field
//  MEMORY_ADDR_WIDTH  10  data-memory address field
//  IMMEDIATE_WIDTH     8  immediate field
//  PC_VALUE_WIDTH      5  program address width; depth = 2**PC_VALUE_WIDTH = 32 words
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  rst            in   1   synchronous, active-high reset
//  start          in   1   begin new program load; write pointer cleared to 0
//  in_valid       in   1   operand bundle valid
//  in_ready       out  1   encoder can accept a bundle this cycle
//  in_opcode      in   4   cpu_instructions code
//  in_selector    in   2   operand source: RF_load / MEM_load / IMM_load
//  in_rf_addr     in   2   register address (STORERF, RF-sourced LOAD/ALU)
//  in_mem_addr    in   10  memory address (STOREMEM, MEM-sourced LOAD/ALU)
//  in_imm         in   8   immediate (IMM-sourced LOAD/ALU)
//  in_jump_target in   5   JUMP target
//  in_last        in   1   bundle is the final instruction of the program
//  prog_we        out  1   program-memory write strobe, one cycle per word
//  prog_addr      out  5   program-memory write address
//  prog_wdata     out  16  encoded instruction word
//  busy / done    out  1   load in progress / load completed (sticky until start or rst)
//  error          out  1   load aborted (sticky until start or rst)
//  error_code     out  2   enc_error_t: ERR_NONE, ERR_OPCODE, ERR_SELECTOR, ERR_OVERFLOW
//  word_count     out  6   words written in current load (0..32)
// BEHAVIOUR
//  Reset: state IDLE; in_ready, prog_we, busy, done, error = 0; prog_addr, prog_wdata,
//   word_count = 0; error_code = ERR_NONE. Reset mid-load abandons it; no further writes.
//  FSM: IDLE -start-> ACCEPT; ACCEPT -(in_valid&&in_ready, fields legal)-> WRITE;
//   ACCEPT -(illegal bundle)-> ERROR; WRITE -> DONE if in_last, ERROR(ERR_OVERFLOW) if 32nd
//   word without in_last, else ACCEPT. DONE/ERROR -start-> ACCEPT; start ignored in ACCEPT/WRITE.
//  in_ready = 1 only in ACCEPT. Handshake at cycle N -> prog_we=1 at N+1 with prog_addr=ptr;
//   ptr and word_count increment at end of N+1. Throughput: one word per 2 cycles.
//  Encoding (all unused bits 0), opcode always in [3:0]:
//   STOREMEM [13:4]=mem_addr.  STORERF [5:4]=rf_addr.  NOP opcode only.  JUMP [8:4]=target.
//   LOAD: [5:4]=selector; RF [7:6]=rf_addr; MEM [15:6]=mem_addr; IMM [15:8]=imm.
//   ALU ops: [5:4]=selector; RF [7:6]; MEM [15:6]; IMM [14:7]=imm, bit 15 = 0.
//  Illegal: opcode not a cpu_instructions member -> ERR_OPCODE; selector 2'b11 on LOAD/ALU ->
//   ERR_SELECTOR. Illegal bundle is consumed, nothing written, word_count unchanged.
//  busy = ACCEPT or WRITE. done and error never both 1.
// STRUCTURE
//  share_pkg gains: enc_state_t, enc_error_t, PROG_DEPTH, field LSB/MSB localparams,
//   function is_valid_opcode(). Reuses cpu_instructions, alu_instructions, RF/MEM/IMM_load.
//  One combinational sub-module: instruction_word_packer (fields in -> 16-bit word + legal flag);
//   FSM, pointer and output registers stay in instruction_encoder.
// TESTING
//  1. start; LOAD IMM in_imm=8'hA5, in_last=1 -> prog_we at addr 0, wdata[15:8]=A5,
//     [7:6]=0, [5:4]=IMM_load, [3:0]=LOAD; done=1, word_count=1.
//  2. ALU op IMM in_imm=8'h3C -> wdata[14:7]=3C, wdata[15]=0; STOREMEM 10'h2F1 -> [13:4]=2F1.
//  3. JUMP target 5'd17 then NOP last -> addr0 [8:4]=17, [15:9]=0; addr1 = NOP code only.
//  4. 32 bundles, in_last never set -> writes addr 0..31, then error=1, ERR_OVERFLOW,
//     in_ready=0, no 33rd write.
//  5. LOAD selector=2'b11 -> no write, error=1, ERR_SELECTOR; start -> error=0, ptr=0.
//  6. rst asserted during WRITE cycle -> next cycle all outputs 0, IDLE; in_valid ignored.

Source files
------------

// File: rtl/instruction_encoder_pkg.sv
// instruction_encoder_pkg: shared opcode/selector codes, encoder state/error types and word field positions
package instruction_encoder_pkg;
  localparam int INSTRUCTION_WIDTH = 16;
  localparam int RF_ADDR_WIDTH = 2;
  localparam int MEMORY_ADDR_WIDTH = 10;
  localparam int IMMEDIATE_WIDTH = 8;
  localparam int PC_VALUE_WIDTH = 5;
  localparam int OPCODE_WIDTH = 4;
  localparam int SEL_WIDTH = 2;
  localparam int PROG_DEPTH = 2 ** PC_VALUE_WIDTH;
  localparam int COUNT_WIDTH = PC_VALUE_WIDTH + 1;
  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 3;
  localparam int OPA_LSB = 4;
  localparam int SEL_MSB = 5;
  localparam int RF_LSB = 6;
  localparam int RF_MSB = 7;
  localparam int MEM_LSB = 6;
  localparam int MEM_MSB = 15;
  localparam int STM_MSB = 13;
  localparam int JMP_MSB = 8;
  localparam int LIMM_LSB = 8;
  localparam int LIMM_MSB = 15;
  localparam int AIMM_LSB = 7;
  localparam int AIMM_MSB = 14;
  typedef enum logic [3:0] {
    NOP, LOAD, STOREMEM, STORERF, JUMP,
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL, ALU_SHR
  } cpu_instructions;
  typedef enum logic [1:0] {RF_load, MEM_load, IMM_load, SEL_BAD} sel_t;
  typedef enum logic [2:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE, S_ERROR} enc_state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_OPCODE, ERR_SELECTOR, ERR_OVERFLOW} enc_error_t;
  function automatic logic is_valid_opcode(input logic [OPCODE_WIDTH-1:0] op);
    return op <= ALU_SHR;
  endfunction
  function automatic logic is_operand_op(input logic [OPCODE_WIDTH-1:0] op);
    return op == LOAD || (op >= ALU_ADD && op <= ALU_SHR);
  endfunction
endpackage

// File: rtl/instruction_encoder_packer.sv
// instruction_word_packer: packs symbolic instruction fields into the decoder's 16-bit word and flags illegal bundles
module instruction_word_packer
  import instruction_encoder_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0]      opcode,
  input  logic [SEL_WIDTH-1:0]         selector,
  input  logic [RF_ADDR_WIDTH-1:0]     rf_addr,
  input  logic [MEMORY_ADDR_WIDTH-1:0] mem_addr,
  input  logic [IMMEDIATE_WIDTH-1:0]   imm,
  input  logic [PC_VALUE_WIDTH-1:0]    jump_target,
  output logic [INSTRUCTION_WIDTH-1:0] word,
  output logic                         legal,
  output enc_error_t                   err
);
  always_comb begin
    word = '0;
    word[OPC_MSB:OPC_LSB] = opcode;
    err = !is_valid_opcode(opcode) ? ERR_OPCODE :
          (is_operand_op(opcode) && selector == SEL_BAD) ? ERR_SELECTOR : ERR_NONE;
    case (opcode)
      STOREMEM: word[STM_MSB:OPA_LSB] = mem_addr;
      STORERF:  word[SEL_MSB:OPA_LSB] = rf_addr;
      JUMP:     word[JMP_MSB:OPA_LSB] = jump_target;
      NOP:      ;
      default: begin
        word[SEL_MSB:OPA_LSB] = selector;
        case (selector)
          RF_load:  word[RF_MSB:RF_LSB] = rf_addr;
          MEM_load: word[MEM_MSB:MEM_LSB] = mem_addr;
          IMM_load: if (opcode == LOAD) word[LIMM_MSB:LIMM_LSB] = imm;
                    else word[AIMM_MSB:AIMM_LSB] = imm;
          default:  ;
        endcase
      end
    endcase
    legal = err == ERR_NONE;
  end
endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: accepts instruction bundles and writes encoded words sequentially into program memory
module instruction_encoder
  import instruction_encoder_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OPCODE_WIDTH-1:0]      in_opcode,
  input  logic [SEL_WIDTH-1:0]         in_selector,
  input  logic [RF_ADDR_WIDTH-1:0]     in_rf_addr,
  input  logic [MEMORY_ADDR_WIDTH-1:0] in_mem_addr,
  input  logic [IMMEDIATE_WIDTH-1:0]   in_imm,
  input  logic [PC_VALUE_WIDTH-1:0]    in_jump_target,
  input  logic                         in_last,
  output logic                         prog_we,
  output logic [PC_VALUE_WIDTH-1:0]    prog_addr,
  output logic [INSTRUCTION_WIDTH-1:0] prog_wdata,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output enc_error_t                   error_code,
  output logic [COUNT_WIDTH-1:0]       word_count
);
  enc_state_t state;
  logic last_q;
  logic legal;
  logic [INSTRUCTION_WIDTH-1:0] word;
  enc_error_t err;
  instruction_word_packer packer (
    .opcode(in_opcode), .selector(in_selector), .rf_addr(in_rf_addr), .mem_addr(in_mem_addr),
    .imm(in_imm), .jump_target(in_jump_target), .word(word), .legal(legal), .err(err)
  );
  // word_count doubles as the write pointer; its low bits are the next program address
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      in_ready <= 1'b0;
      prog_we <= 1'b0;
      prog_addr <= '0;
      prog_wdata <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      error_code <= ERR_NONE;
      word_count <= '0;
      last_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: if (start) begin
          state <= S_ACCEPT;
          in_ready <= 1'b1;
          busy <= 1'b1;
          done <= 1'b0;
          error <= 1'b0;
          error_code <= ERR_NONE;
          word_count <= '0;
        end
        S_ACCEPT: if (in_valid && in_ready) begin
          in_ready <= 1'b0;
          if (legal) begin
            state <= S_WRITE;
            prog_we <= 1'b1;
            prog_addr <= word_count[PC_VALUE_WIDTH-1:0];
            prog_wdata <= word;
            last_q <= in_last;
          end else begin
            state <= S_ERROR;
            busy <= 1'b0;
            error <= 1'b1;
            error_code <= err;
          end
        end
        S_WRITE: begin
          prog_we <= 1'b0;
          word_count <= word_count + 1'b1;
          if (last_q) begin
            state <= S_DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end else if (word_count == COUNT_WIDTH'(PROG_DEPTH - 1)) begin
            state <= S_ERROR;
            busy <= 1'b0;
            error <= 1'b1;
            error_code <= ERR_OVERFLOW;
          end else begin
            state <= S_ACCEPT;
            in_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_encoder.sv
// tb_instruction_encoder: randomized self-checking bench against a field-arithmetic reference model
module tb_instruction_encoder;
  import instruction_encoder_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic in_ready, prog_we, busy, done, error;
  logic [3:0] in_opcode = '0;
  logic [1:0] in_selector = '0, in_rf_addr = '0;
  logic [9:0] in_mem_addr = '0;
  logic [7:0] in_imm = '0;
  logic [4:0] in_jump_target = '0, prog_addr;
  logic [15:0] prog_wdata;
  enc_error_t error_code;
  logic [5:0] word_count;
  int checks = 0, errors = 0, wr_cnt = 0;

  instruction_encoder dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_selector(in_selector), .in_rf_addr(in_rf_addr),
    .in_mem_addr(in_mem_addr), .in_imm(in_imm), .in_jump_target(in_jump_target),
    .in_last(in_last), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .busy(busy), .done(done), .error(error), .error_code(error_code), .word_count(word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (prog_we === 1'b1) wr_cnt++;

  function automatic logic [17:0] model(input int op, sel, rf, mem, imm, tgt);
    int w, e;
    w = op;
    e = int'(ERR_NONE);
    if (op > int'(ALU_SHR)) e = int'(ERR_OPCODE);
    else if (op == int'(STOREMEM)) w += mem * 16;
    else if (op == int'(STORERF)) w += rf * 16;
    else if (op == int'(JUMP)) w += tgt * 16;
    else if (op != int'(NOP)) begin
      if (sel == 3) e = int'(ERR_SELECTOR);
      else w += sel * 16 + (sel == 0 ? rf * 64 : sel == 1 ? mem * 64 :
                            op == int'(LOAD) ? imm * 256 : imm * 128);
    end
    return {e[1:0], w[15:0]};
  endfunction

  task automatic do_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send(input int op, sel, rf, mem, imm, tgt, input bit last);
    for (int i = 0; i < 20 && in_ready !== 1'b1; i++) @(negedge clk);
    if (in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end else begin
      in_opcode = 4'(op); in_selector = 2'(sel); in_rf_addr = 2'(rf);
      in_mem_addr = 10'(mem); in_imm = 8'(imm); in_jump_target = 5'(tgt);
      in_last = last; in_valid = 1'b1;
      @(negedge clk) in_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, prog_we, prog_addr, prog_wdata, busy, done, error, error_code, word_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b addr=%0d wdata=%h busy=%b done=%b err=%b wc=%0d required all 0",
               prog_we, prog_addr, prog_wdata, busy, done, error, word_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_load_imm;
    logic [17:0] exp;
    exp = model(int'(LOAD), int'(IMM_load), 0, 0, 'hA5, 0);
    do_start;
    send(int'(LOAD), int'(IMM_load), 0, 0, 'hA5, 0, 1'b1);
    checks++;
    if ({prog_we, prog_addr, prog_wdata} !== {1'b1, 5'd0, exp[15:0]}) begin
      errors++;
      $display("FAIL load_imm_write: we=%b addr=%0d wdata=%h required 1 0 %h", prog_we, prog_addr, prog_wdata, exp[15:0]);
    end
    checks++;
    if (prog_wdata[15:8] !== 8'hA5) begin
      errors++;
      $display("FAIL load_imm_field: got %h required a5", prog_wdata[15:8]);
    end
    @(negedge clk);
    checks++;
    if ({done, error, busy, word_count} !== {1'b1, 1'b0, 1'b0, 6'd1}) begin
      errors++;
      $display("FAIL load_imm_done: done=%b err=%b busy=%b wc=%0d required 1 0 0 1", done, error, busy, word_count);
    end
  endtask

  task automatic test_alu_store;
    logic [17:0] e0, e1;
    int rf, mem, tgt;
    rf = $urandom_range(0, 3); mem = $urandom_range(0, 1023); tgt = $urandom_range(0, 31);
    e0 = model(int'(ALU_ADD), int'(IMM_load), rf, mem, 'h3C, tgt);
    e1 = model(int'(STOREMEM), int'(IMM_load), rf, 'h2F1, 'h5A, tgt);
    do_start;
    send(int'(ALU_ADD), int'(IMM_load), rf, mem, 'h3C, tgt, 1'b0);
    checks++;
    if (prog_wdata !== e0[15:0] || prog_wdata[14:7] !== 8'h3C || prog_wdata[15] !== 1'b0) begin
      errors++;
      $display("FAIL alu_imm: wdata=%h required %h", prog_wdata, e0[15:0]);
    end
    send(int'(STOREMEM), int'(IMM_load), rf, 'h2F1, 'h5A, tgt, 1'b1);
    checks++;
    if (prog_addr !== 5'd1 || prog_wdata !== e1[15:0] || prog_wdata[13:4] !== 10'h2F1) begin
      errors++;
      $display("FAIL storemem: addr=%0d wdata=%h required 1 %h", prog_addr, prog_wdata, e1[15:0]);
    end
    @(negedge clk);
    checks++;
    if ({done, word_count} !== {1'b1, 6'd2}) begin
      errors++;
      $display("FAIL alu_store_done: done=%b wc=%0d required 1 2", done, word_count);
    end
  endtask

  task automatic test_jump_nop;
    logic [17:0] exp;
    exp = model(int'(JUMP), 0, 0, 0, 0, 17);
    do_start;
    send(int'(JUMP), 3, 3, 1023, 255, 17, 1'b0);
    checks++;
    if (prog_addr !== 5'd0 || prog_wdata !== exp[15:0] || prog_wdata[15:9] !== 7'd0) begin
      errors++;
      $display("FAIL jump: addr=%0d wdata=%h required 0 %h", prog_addr, prog_wdata, exp[15:0]);
    end
    send(int'(NOP), 2, 3, 1023, 255, 31, 1'b1);
    checks++;
    if (prog_addr !== 5'd1 || prog_wdata !== 16'(int'(NOP))) begin
      errors++;
      $display("FAIL nop: addr=%0d wdata=%h required 1 %h", prog_addr, prog_wdata, 16'(int'(NOP)));
    end
  endtask

  task automatic test_overflow;
    int base, op, sel, rf, mem, imm, tgt;
    logic [17:0] exp;
    do_start;
    base = wr_cnt;
    for (int i = 0; i < PROG_DEPTH; i++) begin
      op = $urandom_range(0, 11); sel = $urandom_range(0, 2); rf = $urandom_range(0, 3);
      mem = $urandom_range(0, 1023); imm = $urandom_range(0, 255); tgt = $urandom_range(0, 31);
      exp = model(op, sel, rf, mem, imm, tgt);
      send(op, sel, rf, mem, imm, tgt, 1'b0);
      checks++;
      if (prog_we !== 1'b1 || prog_addr !== 5'(i) || prog_wdata !== exp[15:0]) begin
        errors++;
        $display("FAIL overflow_word%0d: we=%b addr=%0d wdata=%h required 1 %0d %h", i, prog_we, prog_addr, prog_wdata, i, exp[15:0]);
      end
    end
    @(negedge clk);
    checks++;
    if ({error, error_code, in_ready, done, word_count} !== {1'b1, ERR_OVERFLOW, 1'b0, 1'b0, 6'd32}) begin
      errors++;
      $display("FAIL overflow_state: err=%b code=%0d rdy=%b done=%b wc=%0d required 1 3 0 0 32",
               error, error_code, in_ready, done, word_count);
    end
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (wr_cnt - base !== 32) begin
      errors++;
      $display("FAIL overflow_writes: got %0d required 32", wr_cnt - base);
    end
  endtask

  task automatic test_illegal;
    logic [17:0] exp;
    int op;
    exp = model(int'(LOAD), 3, 1, 5, 7, 0);
    do_start;
    send(int'(LOAD), 3, 1, 5, 7, 0, 1'b0);
    checks++;
    if ({prog_we, error, error_code, word_count, busy} !== {1'b0, 1'b1, enc_error_t'(exp[17:16]), 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL bad_selector: we=%b err=%b code=%0d wc=%0d busy=%b required 0 1 %0d 0 0",
               prog_we, error, error_code, word_count, busy, exp[17:16]);
    end
    op = $urandom_range(12, 15);
    exp = model(op, 0, 0, 0, 0, 0);
    do_start;
    send(op, 0, 0, 0, 0, 0, 1'b1);
    checks++;
    if ({prog_we, error, error_code} !== {1'b0, 1'b1, enc_error_t'(exp[17:16])}) begin
      errors++;
      $display("FAIL bad_opcode: we=%b err=%b code=%0d required 0 1 %0d", prog_we, error, error_code, exp[17:16]);
    end
    do_start;
    checks++;
    if ({error, error_code, word_count, busy, in_ready} !== {1'b0, ERR_NONE, 6'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL restart_clear: err=%b code=%0d wc=%0d busy=%b rdy=%b required 0 0 0 1 1",
               error, error_code, word_count, busy, in_ready);
    end
    exp = model(int'(STORERF), 0, 2, 0, 0, 0);
    send(int'(STORERF), 0, 2, 0, 0, 0, 1'b1);
    checks++;
    if ({prog_we, prog_addr, prog_wdata} !== {1'b1, 5'd0, exp[15:0]}) begin
      errors++;
      $display("FAIL restart_ptr: we=%b addr=%0d wdata=%h required 1 0 %h", prog_we, prog_addr, prog_wdata, exp[15:0]);
    end
  endtask

  task automatic test_reset_mid;
    int base;
    do_start;
    send(int'(ALU_SUB), 0, 1, 0, 0, 0, 1'b0);
    base = wr_cnt;
    rst = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, prog_we, prog_addr, prog_wdata, busy, done, error, error_code, word_count} !== '0) begin
      errors++;
      $display("FAIL reset_mid: we=%b addr=%0d wdata=%h busy=%b wc=%0d required all 0",
               prog_we, prog_addr, prog_wdata, busy, word_count);
    end
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (wr_cnt - base !== 1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: writes=%0d busy=%b rdy=%b required 1 0 0", wr_cnt - base, busy, in_ready);
    end
  endtask

  task automatic test_random;
    int n, op, sel, rf, mem, imm, tgt;
    logic [17:0] exp;
    for (int p = 0; p < 4; p++) begin
      n = $urandom_range(1, 8);
      do_start;
      for (int i = 0; i < n; i++) begin
        op = $urandom_range(0, 11); sel = $urandom_range(0, 2); rf = $urandom_range(0, 3);
        mem = $urandom_range(0, 1023); imm = $urandom_range(0, 255); tgt = $urandom_range(0, 31);
        exp = model(op, sel, rf, mem, imm, tgt);
        send(op, sel, rf, mem, imm, tgt, i == n - 1);
        checks++;
        if (prog_we !== 1'b1 || prog_addr !== 5'(i) || prog_wdata !== exp[15:0]) begin
          errors++;
          $display("FAIL random_word p%0d i%0d op%0d: addr=%0d wdata=%h required %0d %h",
                   p, i, op, prog_addr, prog_wdata, i, exp[15:0]);
        end
      end
      @(negedge clk);
      checks++;
      if ({done, error, word_count} !== {1'b1, 1'b0, 6'(n)}) begin
        errors++;
        $display("FAIL random_done p%0d: done=%b err=%b wc=%0d required 1 0 %0d", p, done, error, word_count, n);
      end
    end
  endtask

  initial begin
    test_reset;
    test_load_imm;
    test_alu_store;
    test_jump_nop;
    test_overflow;
    test_illegal;
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
